// File: rtl/seg_scan_display_if.sv
// Pin bundle between the score counter, the display scanner and the board:
// both BCD digit sets and the display controls go in, anode/segment drives come out.
interface seg_scan_display_if;
  logic [3:0] score0, score1, score2, score3;
  logic [3:0] high0, high1, high2, high3;
  logic       sel_high;
  logic       blink;
  logic [3:0] an;
  logic [7:0] seg;

  modport master (
    output score0, score1, score2, score3,
    output high0, high1, high2, high3,
    output sel_high, blink,
    input  an, seg
  );

  modport slave (
    input  score0, score1, score2, score3,
    input  high0, high1, high2, high3,
    input  sel_high, blink,
    output an, seg
  );
endinterface

// File: rtl/seg_scan_display.sv
// Common-anode 4-digit 7-segment scanner. Latches one BCD set per frame so
// updates never tear; adds dead time, leading-zero blanking and optional blink.
module seg_scan_display #(
  parameter int unsigned TICK_DIV     = 100000,
  parameter int unsigned DEAD_CYC     = 16,
  parameter int unsigned LZ_BLANK     = 1,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic               clk,
  input  logic               clr_n,
  seg_scan_display_if.slave  bus
);

  localparam int unsigned CW = $clog2(TICK_DIV);
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    snap_q [4];
  logic [3:0]    snap_d [4];
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          phase_q, phase_d;
  logic [3:0]    an_q, an_d;
  logic [7:0]    seg_q, seg_d;

  logic          tick;
  logic          frame_end;
  logic          lz;
  logic          blank;
  logic [3:0]    digit;

  function automatic logic [7:0] enc(input logic [3:0] v);
    logic [7:0] s;
    case (v)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hBF;
    endcase
    return s;
  endfunction

  always_comb begin
    tick      = (cnt_q == CW'(TICK_DIV - 1));
    frame_end = tick && (idx_q == 2'd3);
    cnt_d     = tick ? '0 : cnt_q + 1'b1;
    idx_d     = tick ? idx_q + 2'd1 : idx_q;

    snap_d = snap_q;
    if (frame_end) begin
      snap_d[0] = bus.sel_high ? bus.high0 : bus.score0;
      snap_d[1] = bus.sel_high ? bus.high1 : bus.score1;
      snap_d[2] = bus.sel_high ? bus.high2 : bus.score2;
      snap_d[3] = bus.sel_high ? bus.high3 : bus.score3;
    end

    fcnt_d  = fcnt_q;
    phase_d = phase_q;
    if (frame_end) begin
      if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end

    // Digit idx is a leading zero when it and every more-significant digit are zero.
    lz = (idx_q != 2'd0);
    for (int unsigned k = 0; k < 4; k++) begin
      if ((k >= 32'(idx_q)) && (snap_q[k] != 4'd0)) lz = 1'b0;
    end

    blank = (cnt_q < CW'(DEAD_CYC)) || (bus.blink && phase_q) ||
            ((LZ_BLANK != 0) && lz);
    digit = snap_q[idx_q];
    an_d  = blank ? '1 : ~(4'b0001 << idx_q);
    seg_d = blank ? '1 : enc(digit);
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      fcnt_q  <= '0;
      phase_q <= 1'b0;
      an_q    <= '1;
      seg_q   <= '1;
      for (int unsigned k = 0; k < 4; k++) snap_q[k] <= '0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      fcnt_q  <= fcnt_d;
      phase_q <= phase_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      for (int unsigned k = 0; k < 4; k++) snap_q[k] <= snap_d[k];
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;

endmodule
